// File: rtl/ic_qz_pkg.sv
// ic_qz_pkg: shared constants for the JPEG quantisation multiplier.
//   - QZ_MODE_*        : per-beat rounding / bypass mode encodings
//   - QZ_*_W, QZ_SHIFT : default datapath widths and reciprocal fraction bits
//   - QZ_SAT_W         : width of the saturation statistics counter
package ic_qz_pkg;

    localparam int QZ_DATA_W  = 16;
    localparam int QZ_RECIP_W = 13;
    localparam int QZ_SHIFT   = 12;
    localparam int QZ_OUT_W   = 12;
    localparam int QZ_SAT_W   = 16;

    // 2'b11 is reserved and decodes as round-nearest.
    typedef enum logic [1:0] {
        QZ_MODE_ROUND  = 2'b00,
        QZ_MODE_TRUNC  = 2'b01,
        QZ_MODE_BYPASS = 2'b10,
        QZ_MODE_RSVD   = 2'b11
    } qz_mode_e;

endpackage

// File: rtl/ic_qz_round_sat.sv
// ic_qz_round_sat: combinational rescale / round / saturate of one product.
//   prod_i : full-width signed product (coefficient * reciprocal)
//   mode_i : round-nearest, truncate or bypass
//   byp_i  : original coefficient, used in bypass mode
//   q_o    : clamped signed result
//   sat_o  : result was clamped
module ic_qz_round_sat
    import ic_qz_pkg::*;
#(
    parameter int DATA_W  = QZ_DATA_W,
    parameter int RECIP_W = QZ_RECIP_W,
    parameter int SHIFT   = QZ_SHIFT,
    parameter int OUT_W   = QZ_OUT_W,
    localparam int PW     = DATA_W + RECIP_W + 1
) (
    input  logic signed [PW-1:0]     prod_i,
    input  logic        [1:0]        mode_i,
    input  logic signed [DATA_W-1:0] byp_i,
    output logic signed [OUT_W-1:0]  q_o,
    output logic                     sat_o
);

    // One extra bit so that negating the magnitude can never overflow.
    localparam int VW    = PW + 1;
    localparam int QMAXI = (1 << (OUT_W - 1)) - 1;
    localparam logic signed [VW-1:0] QMAX = VW'(QMAXI);
    localparam logic signed [VW-1:0] QMIN = -VW'(QMAXI) - VW'(1);

    logic                 neg;
    logic [PW-1:0]        mag;
    logic [PW-1:0]        rnd;
    logic [PW-1:0]        qmag;
    logic signed [VW-1:0] val;

    always_comb begin
        neg  = prod_i[PW-1];
        mag  = neg ? -prod_i : prod_i;
        // Rounding on the magnitude makes ties go away from zero.
        rnd  = (mode_i == QZ_MODE_TRUNC) ? '0 : (PW'(1) << (SHIFT - 1));
        qmag = (mag + rnd) >> SHIFT;
        if (mode_i == QZ_MODE_BYPASS)
            val = VW'(byp_i);
        else if (neg)
            val = -$signed({1'b0, qmag});   // qmag==0 yields plain 0
        else
            val = $signed({1'b0, qmag});
        sat_o = 1'b0;
        q_o   = val[OUT_W-1:0];
        if (val > QMAX) begin
            q_o   = QMAX[OUT_W-1:0];
            sat_o = 1'b1;
        end else if (val < QMIN) begin
            q_o   = QMIN[OUT_W-1:0];
            sat_o = 1'b1;
        end
    end

endmodule

// File: rtl/ic_qz_quant_pipe.sv
// ic_qz_quant_pipe: PIPE-stage quantisation multiplier with valid/ready.
//   clock/aclr_n        : rising-edge clock, async active-low reset
//   clken               : global enable, low freezes all state
//   clr_stats           : synchronous clear of sat_count
//   in_*                : coefficient, reciprocal, mode, tag, last + handshake
//   out_*               : quantised result, tag, last, clamp flag + handshake
//   sat_count           : saturating count of accepted clamped beats
// Stage 0 registers the product; stages 1..PIPE-2 are delay; the output
// registers form stage PIPE-1 and are fed through ic_qz_round_sat.
module ic_qz_quant_pipe
    import ic_qz_pkg::*;
#(
    parameter int DATA_W  = QZ_DATA_W,
    parameter int RECIP_W = QZ_RECIP_W,
    parameter int SHIFT   = QZ_SHIFT,
    parameter int OUT_W   = QZ_OUT_W,
    parameter int PIPE    = 3,
    parameter int TAG_W   = 6
) (
    input  logic                     clock,
    input  logic                     aclr_n,
    input  logic                     clken,
    input  logic                     clr_stats,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [RECIP_W-1:0]       in_recip,
    input  logic [1:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     out_last,
    output logic                     out_sat,
    output logic [QZ_SAT_W-1:0]      sat_count
);

    localparam int PW = DATA_W + RECIP_W + 1;
    localparam int NS = PIPE - 1;   // stages ahead of the output registers

    logic                    advance;
    logic signed [PW-1:0]    prod_d;
    logic [NS-1:0]           vld_q;
    logic [NS-1:0]           last_q;
    logic signed [PW-1:0]    prod_q [NS];
    logic [1:0]              mode_q [NS];
    logic signed [DATA_W-1:0] byp_q [NS];
    logic [TAG_W-1:0]        tag_q  [NS];

    logic                    out_valid_q, out_last_q, out_sat_q;
    logic signed [OUT_W-1:0] out_data_q;
    logic [TAG_W-1:0]        out_tag_q;
    logic [QZ_SAT_W-1:0]     sat_cnt_q;

    logic signed [OUT_W-1:0] rs_q;
    logic                    rs_sat;

    assign advance  = clken & (~out_valid_q | out_ready);
    assign in_ready = advance;
    // Reciprocal is zero-extended so the multiply stays signed.
    assign prod_d   = in_data * $signed({1'b0, in_recip});

    ic_qz_round_sat #(
        .DATA_W (DATA_W),
        .RECIP_W(RECIP_W),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W)
    ) u_round_sat (
        .prod_i(prod_q[NS-1]),
        .mode_i(mode_q[NS-1]),
        .byp_i (byp_q[NS-1]),
        .q_o   (rs_q),
        .sat_o (rs_sat)
    );

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            vld_q  <= '0;
            last_q <= '0;
            for (int i = 0; i < NS; i++) begin
                prod_q[i] <= '0;
                mode_q[i] <= '0;
                byp_q[i]  <= '0;
                tag_q[i]  <= '0;
            end
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_last_q  <= 1'b0;
            out_sat_q   <= 1'b0;
        end else if (advance) begin
            vld_q[0]  <= in_valid;
            last_q[0] <= in_last;
            prod_q[0] <= prod_d;
            mode_q[0] <= in_mode;
            byp_q[0]  <= in_data;
            tag_q[0]  <= in_tag;
            for (int i = 1; i < NS; i++) begin
                vld_q[i]  <= vld_q[i-1];
                last_q[i] <= last_q[i-1];
                prod_q[i] <= prod_q[i-1];
                mode_q[i] <= mode_q[i-1];
                byp_q[i]  <= byp_q[i-1];
                tag_q[i]  <= tag_q[i-1];
            end
            out_valid_q <= vld_q[NS-1];
            out_data_q  <= rs_q;
            out_tag_q   <= tag_q[NS-1];
            out_last_q  <= last_q[NS-1];
            // Bubbles never report a clamp.
            out_sat_q   <= vld_q[NS-1] & rs_sat;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n)
            sat_cnt_q <= '0;
        else if (clken) begin
            if (clr_stats)
                sat_cnt_q <= '0;
            else if (out_valid_q && out_ready && out_sat_q && (sat_cnt_q != '1))
                sat_cnt_q <= sat_cnt_q + 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_last  = out_last_q;
    assign out_sat   = out_sat_q;
    assign sat_count = sat_cnt_q;

endmodule

// File: doc/ic_qz_quant_pipe.md
Name: ic_qz_quant_pipe

Overview:
Parametrised quantisation multiplier stage for the JPEG compression path. It sits between the DCT output and the zig-zag reorder buffer.
- Multiplies each signed DCT coefficient by an unsigned fixed-point reciprocal of the quantisation-table entry.
- Rescales, rounds and saturates the product.
- Adds valid/ready flow control, a selectable rounding/bypass mode, sideband tag passthrough and saturation statistics.

Parameters:
DATA_W, 16, signed coefficient input width
RECIP_W, 13, unsigned reciprocal width (zero-extended before the signed multiply)
SHIFT, 12, fractional bits of the reciprocal (1.0 = 2^SHIFT)
OUT_W, 12, signed quantised output width
PIPE, 3, stage count, input beat to out_valid, legal range 2..6
TAG_W, 6, sideband tag width (zig-zag index)

Ports:
clock  in  1  rising-edge clock
aclr_n  in  1  asynchronous active-low reset
clken  in  1  global enable; low freezes all state
clr_stats  in  1  synchronous clear of sat_count
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_data  in  DATA_W  signed coefficient
in_recip  in  RECIP_W  unsigned reciprocal
in_mode  in  2  00 round-nearest, 01 truncate, 10 bypass, 11 treated as 00
in_tag  in  TAG_W  sideband tag, passed through
in_last  in  1  last coefficient of the block, passed through
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_data  out  OUT_W  signed quantised result
out_tag  out  TAG_W  tag aligned to out_data
out_last  out  1  last flag aligned to out_data
out_sat  out  1  this beat was clamped
sat_count  out  16  saturating count of clamped beats

Behaviour:
- Reset: all stage valid bits 0; out_valid=0, out_data=0, out_tag=0, out_last=0, out_sat=0, sat_count=0. Reset applies asynchronously at any time, including mid-stream. Beats in flight are discarded; no partial output appears after release.
- Advance: advance = clken & (~out_valid | out_ready).
- Input handshake: in_ready = advance, combinational. A beat transfers when in_valid & in_ready.
- Pipeline motion:
  - When advance=1, every stage shifts one position.
  - A bubble enters stage 0 when no beat transfers.
  - When advance=0, every stage, including the outputs, holds its value.
- Latency: exactly PIPE cycles from transfer to out_valid while out_ready is held high. Throughput is 1 beat per cycle. Beat order is preserved.
- Mode, tag and last are captured with the data and travel with it. Mode can change on every beat.
- Arithmetic:
  - p = in_data * {0,in_recip}, held at full width DATA_W+RECIP_W+1. The multiply occupies stage 0; the multiplier may be retimed across stages 0..PIPE-2.
  - m = |p|.
  - Round-nearest: q = (m + 2^(SHIFT-1)) >> SHIFT. Ties round away from zero.
  - Truncate: q = m >> SHIFT, i.e. toward zero.
  - The sign of p is then reapplied to q.
  - Bypass: q = in_data, and in_recip is ignored.
- Saturation:
  - Clamp q to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - out_sat=1 when clamping occurred.
  - A product of zero gives 0, never -0.
- Statistics:
  - sat_count increments by 1 when a beat with out_sat=1 is accepted (out_valid & out_ready).
  - sat_count holds at 0xFFFF.
  - clr_stats takes priority over an increment in the same cycle.
- clken=0: in_ready=0, outputs hold, sat_count holds. out_valid stays asserted if already high.

Decomposition:
- Package ic_qz_pkg holds:
  - mode encodings QZ_MODE_ROUND, QZ_MODE_TRUNC, QZ_MODE_BYPASS.
  - default width constants for DATA_W, RECIP_W, SHIFT and OUT_W.
  - the sat_count width of 16.
- Sub-module ic_qz_round_sat is purely combinational. It takes the full product, mode and bypass data, and returns q and the sat flag. It sits in the final pipeline stage.

Test Plan:
- Defaults, out_ready=1. Beat data=100, recip=256 in mode 00 -> out_data=6 exactly 3 cycles after transfer, out_sat=0. Same beat in mode 01 -> 6.
- Tie cases, recip=2048:
  - data=3 -> 2 in mode 00, 1 in mode 01.
  - data=-3 -> -2 in mode 00, -1 in mode 01.
  - data=-40 -> -20 in both modes.
- Saturation: data=32767, recip=4095 -> out_data=2047, out_sat=1. data=-32768, recip=4095 -> -2048, out_sat=1. sat_count=2 after both beats are accepted. Pulse clr_stats -> 0.
- Backpressure: stream 8 beats tagged 0..7 with last on tag 7, and hold out_ready=0 for 5 cycles mid-stream.
  - No beat is lost or duplicated; tags emerge in order 0..7.
  - in_ready=0 while the output is stalled.
  - out_last is set only on tag 7.
- Bypass and mode mix: alternate modes 10/00 per beat with data=2047 and 3000, recip=4096.
  - Bypass beats -> 2047, then 2047 with out_sat=1.
  - Round beats -> 2047, then 2047 with out_sat=1.
- Reset and clken: assert aclr_n low for 1 cycle with 3 beats in flight -> out_valid=0 immediately, and no stale beats after release. clken=0 for 4 cycles -> all outputs and sat_count frozen, in_ready=0.
